// File: rtl/gpio_pad_cfg_seq.sv
// gpio_pad_cfg_seq
//   Static mode-pin sequencer for N sky130 gpiov2 pads. Each single-pad
//   reconfiguration request is applied glitch-free in five steps: isolate the
//   pad output, settle, load the new config, settle again, then release.
//
//   Optional feature macro: GPIO_PAD_CFG_SEQ_STARTUP_EN
//     defined   : after reset all pads are isolated at 8'h80 and are walked to
//                 DEFAULT_CFG one at a time before requests are accepted.
//     undefined : pads leave reset at DEFAULT_CFG, not isolated, ready at once.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_valid_i/ready_o   request handshake
//   req_pad_i, req_cfg_i  target pad index and new config word
//   done_o, err_o         completion pulse; err_o marks a rejected index
//   busy_o                sequencer not idle
//   core_oe_n_i           core output enables (active-low)
//   pad_*_o               pad mode pins; pad k owns bit k (DM: bits 3k+2:3k)
//
// Config word: [2:0] dm, [3] inp_dis, [4] slow, [5] vtrip_sel,
//              [6] ib_mode_sel, [7] oe_allow
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | ready for a request
// ISOLATE  | target pad forced tristate, SETTLE-cycle quiesce
// APPLY    | single cycle; config loaded at the exit edge
// RELEASE  | SETTLE-cycle quiesce with the new config in place
// DONE     | single cycle; isolation lifted, done_o pulse
// STARTUP  | (macro only) post-reset walk of all pads to DEFAULT_CFG
module gpio_pad_cfg_seq #(
  parameter int         N           = 8,
  parameter int         SETTLE      = 4,
  parameter logic [7:0] DEFAULT_CFG = 8'h02
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [$clog2(N)-1:0] req_pad_i,
  input  logic [7:0]           req_cfg_i,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 busy_o,
  input  logic [N-1:0]         core_oe_n_i,
  output logic [N-1:0]         pad_oe_n_o,
  output logic [3*N-1:0]       pad_dm_o,
  output logic [N-1:0]         pad_inp_dis_o,
  output logic [N-1:0]         pad_slow_o,
  output logic [N-1:0]         pad_vtrip_sel_o,
  output logic [N-1:0]         pad_ib_mode_sel_o
);

  localparam int PW = $clog2(N);
  localparam int CW = $clog2(2*SETTLE+2);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISOLATE = 3'd1,
    S_APPLY   = 3'd2,
    S_RELEASE = 3'd3,
`ifdef GPIO_PAD_CFG_SEQ_STARTUP_EN
    S_DONE    = 3'd4,
    S_STARTUP = 3'd5
`else
    S_DONE    = 3'd4
`endif
  } state_e;

`ifdef GPIO_PAD_CFG_SEQ_STARTUP_EN
  localparam state_e     RST_STATE = S_STARTUP;
  localparam logic [N-1:0] ISO_RST = {N{1'b1}};
  localparam logic [7:0] CFG_RST   = 8'h80;
  // Per-pad startup slot is 2*SETTLE+2 cycles, counted down to zero.
  localparam logic [CW-1:0] SC_INIT = CW'(2*SETTLE+1);
  localparam logic [CW-1:0] SC_APPLY = CW'(SETTLE+1);
`else
  localparam state_e     RST_STATE = S_IDLE;
  localparam logic [N-1:0] ISO_RST = '0;
  localparam logic [7:0] CFG_RST   = DEFAULT_CFG;
`endif

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [PW-1:0]   pad_q;
  logic [7:0]      new_cfg_q;
  logic            err_q;
  logic [N-1:0]    iso_q;
  logic [7:0]      cfg_q [N];
  logic            pad_oor;

`ifdef GPIO_PAD_CFG_SEQ_STARTUP_EN
  logic [CW-1:0]   sc_q;
  logic [PW-1:0]   spad_q;
  logic            last_pad;
  assign last_pad = (32'(spad_q) == 32'(N-1));
`endif

  // Only reachable when N is not a power of two.
  assign pad_oor = (32'(req_pad_i) >= 32'(N));

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= RST_STATE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (req_valid_i) state_d = pad_oor ? S_DONE : S_ISOLATE;
      S_ISOLATE: if (cnt_q == '0) state_d = S_APPLY;
      S_APPLY:   state_d = S_RELEASE;
      S_RELEASE: if (cnt_q == '0) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
`ifdef GPIO_PAD_CFG_SEQ_STARTUP_EN
      S_STARTUP: if ((sc_q == '0) && last_pad) state_d = S_IDLE;
`endif
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = (state_q == S_IDLE);
    busy_o      = (state_q != S_IDLE);
    done_o      = (state_q == S_DONE);
    err_o       = (state_q == S_DONE) & err_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      pad_q     <= '0;
      new_cfg_q <= '0;
      err_q     <= 1'b0;
      iso_q     <= ISO_RST;
      for (int k = 0; k < N; k++) cfg_q[k] <= CFG_RST;
`ifdef GPIO_PAD_CFG_SEQ_STARTUP_EN
      sc_q      <= SC_INIT;
      spad_q    <= '0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            pad_q     <= req_pad_i;
            new_cfg_q <= req_cfg_i;
            err_q     <= pad_oor;
            cnt_q     <= CW'(SETTLE-1);
            if (!pad_oor) iso_q[req_pad_i] <= 1'b1;
          end
        end
        // Reload on exit so RELEASE starts with a full count.
        S_ISOLATE: cnt_q <= (cnt_q == '0) ? CW'(SETTLE-1) : cnt_q - CW'(1);
        S_APPLY:   cfg_q[pad_q] <= new_cfg_q;
        S_RELEASE: begin
          if (cnt_q == '0) iso_q[pad_q] <= 1'b0;
          else             cnt_q <= cnt_q - CW'(1);
        end
`ifdef GPIO_PAD_CFG_SEQ_STARTUP_EN
        S_STARTUP: begin
          if (sc_q == SC_APPLY) cfg_q[spad_q] <= DEFAULT_CFG;
          if (sc_q == '0) begin
            iso_q[spad_q] <= 1'b0;
            sc_q          <= SC_INIT;
            spad_q        <= spad_q + PW'(1);
          end else begin
            sc_q <= sc_q - CW'(1);
          end
        end
`endif
        default: ;
      endcase
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_pad
    assign pad_oe_n_o[k]        = core_oe_n_i[k] | iso_q[k] | ~cfg_q[k][7];
    assign pad_dm_o[3*k +: 3]   = cfg_q[k][2:0];
    assign pad_inp_dis_o[k]     = cfg_q[k][3];
    assign pad_slow_o[k]        = cfg_q[k][4];
    assign pad_vtrip_sel_o[k]   = cfg_q[k][5];
    assign pad_ib_mode_sel_o[k] = cfg_q[k][6];
  end

endmodule

// File: tb/tb_gpio_pad_cfg_seq.sv
`timescale 1ns/1ps
module tb_gpio_pad_cfg_seq;
  localparam logic [7:0] DEF = 8'h02;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifndef GPIO_PAD_CFG_SEQ_STARTUP_EN
  localparam int N  = 8;
  localparam int S  = 4;
  localparam int N6 = 6;

  logic           valid = 1'b0;
  logic [2:0]     pad   = '0;
  logic [7:0]     cfg   = '0;
  logic [N-1:0]   core_oe_n = '0;
  logic           ready, done, err, busy;
  logic [N-1:0]   oe_n, inp_dis, slow, vtrip, ib;
  logic [3*N-1:0] dm;

  gpio_pad_cfg_seq #(.N(N), .SETTLE(S), .DEFAULT_CFG(DEF)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(valid), .req_ready_o(ready),
    .req_pad_i(pad), .req_cfg_i(cfg), .done_o(done), .err_o(err), .busy_o(busy),
    .core_oe_n_i(core_oe_n), .pad_oe_n_o(oe_n), .pad_dm_o(dm),
    .pad_inp_dis_o(inp_dis), .pad_slow_o(slow), .pad_vtrip_sel_o(vtrip),
    .pad_ib_mode_sel_o(ib)
  );

  logic            valid6 = 1'b0;
  logic [2:0]      pad6   = '0;
  logic [7:0]      cfg6   = '0;
  logic [N6-1:0]   core6  = '0;
  logic            ready6, done6, err6, busy6;
  logic [N6-1:0]   oe_n6, inp6, slow6, vt6, ib6;
  logic [3*N6-1:0] dm6;

  gpio_pad_cfg_seq #(.N(N6), .SETTLE(S), .DEFAULT_CFG(DEF)) dut6 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(valid6), .req_ready_o(ready6),
    .req_pad_i(pad6), .req_cfg_i(cfg6), .done_o(done6), .err_o(err6), .busy_o(busy6),
    .core_oe_n_i(core6), .pad_oe_n_o(oe_n6), .pad_dm_o(dm6),
    .pad_inp_dis_o(inp6), .pad_slow_o(slow6), .pad_vtrip_sel_o(vt6),
    .pad_ib_mode_sel_o(ib6)
  );

  // Reference model: a request accepted in cycle t0 is described purely by
  // its offset d = cycle - t0 against the documented timeline.
  int           cyc = 0;
  bit           have = 1'b0;
  int           t0 = 0;
  int           mpad = 0;
  logic [7:0]   mnew = '0;
  bit           merr = 1'b0;
  logic [7:0]   cfg_m [N];
  bit           e_ready = 1'b1, e_busy = 1'b0, e_done = 1'b0, e_err = 1'b0;
  logic [N-1:0] e_iso = '0;
  bit           chk_en = 1'b0;

  always @(posedge clk) begin
    int d;
    int last;
    if (rst) begin
      have = 1'b0;
      for (int k = 0; k < N; k++) cfg_m[k] = DEF;
    end else if (e_ready && valid) begin
      have = 1'b1; t0 = cyc; mpad = int'(pad); mnew = cfg; merr = (mpad >= N);
    end
    cyc++;
    e_iso = '0; e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0;
    if (have) begin
      d    = cyc - t0;
      last = merr ? 1 : 2*S+2;
      if (d > last) have = 1'b0;
      else begin
        e_busy = 1'b1;
        e_done = (d == last);
        e_err  = e_done && merr;
        if (!merr && d <= 2*S+1) e_iso[mpad] = 1'b1;
        if (!merr && d == S+2)   cfg_m[mpad] = mnew;
      end
    end
    e_ready = !e_busy;
  end

  always @(negedge clk) begin
    logic [N-1:0]   e_oe, e_inp, e_slow, e_vt, e_ib;
    logic [3*N-1:0] e_dm;
    if (chk_en) begin
      for (int k = 0; k < N; k++) begin
        e_oe[k]       = core_oe_n[k] | e_iso[k] | ~cfg_m[k][7];
        e_dm[3*k +: 3] = cfg_m[k][2:0];
        e_inp[k]      = cfg_m[k][3];
        e_slow[k]     = cfg_m[k][4];
        e_vt[k]       = cfg_m[k][5];
        e_ib[k]       = cfg_m[k][6];
      end
      check("ready", ready, e_ready);
      check("busy", busy, e_busy);
      check("done", done, e_done);
      check("err", err, e_err);
      check("oe_n", oe_n, e_oe);
      check("dm", dm, e_dm);
      check("modes", {inp_dis, slow, vtrip, ib}, {e_inp, e_slow, e_vt, e_ib});
    end
  end

  task automatic run_req(input logic [2:0] p, input logic [7:0] c, output int done_d);
    int ts;
    done_d = -1;
    valid = 1'b1; pad = p; cfg = c; ts = cyc;
    tick();
    valid = 1'b0;
    for (int i = 1; i <= 3*S+6 && done_d < 0; i++) begin
      @(negedge clk);
      if (done) done_d = cyc - ts;
      tick();
    end
  endtask

  typedef struct {
    logic [2:0] pad;
    logic [7:0] cfg;
    logic       core;
    logic       oe_n;
    logic [2:0] dm;
    logic [3:0] flags; // {ib, vtrip, slow, inp_dis}
  } vec_t;

  vec_t vecs [7];

  initial begin
    int first_dm, done_at, err_at, oe_first, oe_last, dd, acc2, nd, d1, d2;
    vecs[0] = '{3'd3, 8'h86, 1'b0, 1'b0, 3'b110, 4'b0000};
    vecs[1] = '{3'd5, 8'h7F, 1'b0, 1'b1, 3'b111, 4'b1111};
    vecs[2] = '{3'd2, 8'hB8, 1'b0, 1'b0, 3'b000, 4'b0111};
    vecs[3] = '{3'd7, 8'hFF, 1'b1, 1'b1, 3'b111, 4'b1111};
    vecs[4] = '{3'd0, 8'hC1, 1'b0, 1'b0, 3'b001, 4'b1000};
    vecs[5] = '{3'd3, 8'h86, 1'b0, 1'b0, 3'b110, 4'b0000};
    vecs[6] = '{3'd3, 8'h06, 1'b0, 1'b1, 3'b110, 4'b0000};

    rst = 1'b1;
    repeat (3) tick();
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_ready", ready, 1'b1);
    check("rst_dm", dm, {N{DEF[2:0]}});
    check("rst6_ready", ready6, 1'b1);
    tick();
    rst = 1'b0;
    tick();

    // Basic reconfiguration with timeline measurement.
    core_oe_n = '0;
    first_dm = -1; done_at = -1; err_at = -1; oe_first = -1; oe_last = -1;
    valid = 1'b1; pad = 3'd3; cfg = 8'h86; t0 = cyc;
    d1 = cyc;
    tick();
    valid = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      dd = cyc - d1;
      if (dm[11:9] == 3'b110 && first_dm < 0) first_dm = dd;
      if (done && done_at < 0) begin done_at = dd; err_at = int'(err); end
      if (oe_n[3]) begin if (oe_first < 0) oe_first = dd; oe_last = dd; end
      tick();
    end
    check("basic_dm_cycle", first_dm, S+2);
    check("basic_done_cycle", done_at, 2*S+2);
    check("basic_err", err_at, 0);
    check("basic_iso_first", oe_first, 1);
    check("basic_iso_last", oe_last, 2*S+1);

    // Table of requests, final pad state checked after completion.
    for (int v = 0; v < 7; v++) begin
      core_oe_n = {N{vecs[v].core}};
      run_req(vecs[v].pad, vecs[v].cfg, dd);
      check("vec_done_lat", dd, 2*S+2);
      @(negedge clk);
      check("vec_oe_n", oe_n[vecs[v].pad], vecs[v].oe_n);
      check("vec_dm", dm[3*vecs[v].pad +: 3], vecs[v].dm);
      check("vec_flags", {ib[vecs[v].pad], vtrip[vecs[v].pad], slow[vecs[v].pad],
                          inp_dis[vecs[v].pad]}, vecs[v].flags);
      tick();
    end

    // Back-to-back with valid held high.
    core_oe_n = '0;
    d1 = -1; d2 = -1; acc2 = -1;
    valid = 1'b1; pad = 3'd0; cfg = 8'h81; dd = cyc;
    tick();
    pad = 3'd1; cfg = 8'hC5;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (done && d1 < 0) d1 = cyc - dd;
      else if (done && d2 < 0) d2 = cyc - dd;
      if (ready && valid && acc2 < 0 && (cyc - dd) > 0) acc2 = cyc - dd;
      tick();
      if (acc2 >= 0) valid = 1'b0;
    end
    check("b2b_done1", d1, 2*S+2);
    check("b2b_accept2", acc2, 2*S+3);
    check("b2b_done2", d2, 4*S+5);

    // Out-of-range index on the N=6 instance.
    valid6 = 1'b1; pad6 = 3'd7; cfg6 = 8'hFF;
    tick();
    valid6 = 1'b0;
    @(negedge clk);
    check("oor_done", done6, 1'b1);
    check("oor_err", err6, 1'b1);
    check("oor_ready_low", ready6, 1'b0);
    tick();
    @(negedge clk);
    check("oor_ready_back", ready6, 1'b1);
    check("oor_done_clr", done6, 1'b0);
    check("oor_pads", {oe_n6, dm6, inp6, slow6, vt6, ib6},
          {{N6{1'b1}}, {N6{DEF[2:0]}}, {4*N6{1'b0}}});
    tick();

    // Reset during APPLY drops the request.
    valid = 1'b1; pad = 3'd4; cfg = 8'hFF;
    tick();
    valid = 1'b0;
    repeat (S) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mrst_ready", ready, 1'b1);
    check("mrst_cfg4", {ib[4], vtrip[4], slow[4], inp_dis[4], dm[14:12]}, {4'b0000, DEF[2:0]});
    nd = 0;
    tick();
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) nd++;
      tick();
    end
    check("mrst_no_done", nd, 0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      core_oe_n = N'($urandom);
      valid     = ($urandom_range(0, 3) == 0);
      pad       = 3'($urandom_range(0, 7));
      cfg       = 8'($urandom);
      tick();
    end
    valid = 1'b0;
    repeat (2*S+4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

`else
  localparam int N = 4;
  localparam int S = 2;

  logic           valid = 1'b0;
  logic [1:0]     pad   = '0;
  logic [7:0]     cfg   = '0;
  logic [N-1:0]   core_oe_n = '0;
  logic           ready, done, err, busy;
  logic [N-1:0]   oe_n, inp_dis, slow, vtrip, ib;
  logic [3*N-1:0] dm;

  gpio_pad_cfg_seq #(.N(N), .SETTLE(S), .DEFAULT_CFG(DEF)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(valid), .req_ready_o(ready),
    .req_pad_i(pad), .req_cfg_i(cfg), .done_o(done), .err_o(err), .busy_o(busy),
    .core_oe_n_i(core_oe_n), .pad_oe_n_o(oe_n), .pad_dm_o(dm),
    .pad_inp_dis_o(inp_dis), .pad_slow_o(slow), .pad_vtrip_sel_o(vtrip),
    .pad_ib_mode_sel_o(ib)
  );

  initial begin
    int reach [N];
    int rise, nd;
    for (int k = 0; k < N; k++) reach[k] = -1;
    rise = -1; nd = 0;
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("st_rst_ready", ready, 1'b0);
    check("st_rst_busy", busy, 1'b1);
    check("st_rst_oe", oe_n, {N{1'b1}});
    check("st_rst_dm", dm, '0);
    tick();
    rst = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++)
        if (dm[3*k +: 3] == DEF[2:0] && reach[k] < 0) reach[k] = c;
      if (ready && rise < 0) rise = c;
      if (done) nd++;
      tick();
    end
    for (int k = 0; k < N; k++) check("st_pad_reach", reach[k], 6*k+4);
    check("st_ready_rise", rise, N*(2*S+2)+1);
    check("st_no_done", nd, 0);
    @(negedge clk);
    check("st_busy_end", busy, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
`endif

endmodule
